// File: rtl/dark_mem_responder.sv
// ---------------------------------------------------------------------------
// dark_mem_responder
//
// Single-clock behavioural memory that answers a simple core bus. It has two
// independent paths into one 2**ADDR_W x 32-bit word array:
//   - an instruction port that refetches IDATA on every clock, and
//   - a data port run by a small IDLE/WAIT/ACK FSM that stalls the core with
//     HLT for exactly WAIT_CYC cycles per access.
//
// Ports
//   CLK        clock; all state changes on its rising edge
//   RES        asynchronous active-high reset (memory contents are kept)
//   IADDR      instruction byte address
//   IDATA      registered instruction word (NOP_WORD under reset / out of range)
//   DADDR      data byte address (held stable by the core while HLT=1)
//   DATAO      write data from the core
//   DATAI      registered read data; holds until the next read load
//   BE         byte enables, BE[n] selects bits 8n+7:8n
//   WR, RD     data write / read request (both high = write only, error)
//   HLT        combinational stall to the core
//   ERR        sticky error flag, cleared only by RES
//   dbg_state  current data FSM state (0 = IDLE, 1 = WAIT, 2 = ACK)
//
// Handshake: a request is RD|WR sampled while the FSM is IDLE. HLT is high
// from the IDLE cycle that sees the request through the last WAIT cycle and
// low in ACK. Read data is valid in the ACK cycle. A write commits on the
// edge leaving ACK using the WR/BE/DATAO values present at that edge, so a
// core that drops WR before ACK suppresses its own write.
// ---------------------------------------------------------------------------
module dark_mem_responder #(
    parameter int          ADDR_W   = 10,
    parameter int          WAIT_CYC = 1,
    parameter logic [31:0] NOP_WORD = 32'h00000013
) (
    input  logic        CLK,
    input  logic        RES,
    input  logic [31:0] IADDR,
    output logic [31:0] IDATA,
    input  logic [31:0] DADDR,
    input  logic [31:0] DATAO,
    output logic [31:0] DATAI,
    input  logic [3:0]  BE,
    input  logic        WR,
    input  logic        RD,
    output logic        HLT,
    output logic        ERR,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    localparam int         DEPTH    = 1 << ADDR_W;
    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYC - 1);
    // With a single wait cycle the IDLE cycle itself is the only HLT cycle,
    // so the FSM goes straight from IDLE to ACK.
    localparam bit         HAS_WAIT = (WAIT_CYC > 1);

    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] mem [DEPTH];

    // ------------------------------------------------------------------
    // Address decode: word index from bits ADDR_W+1:2, in range only when
    // every bit above the index is zero. Bits 1:0 are ignored.
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] iidx;
    logic [ADDR_W-1:0] didx;
    logic              irange;
    logic              drange;
    logic              unused_addr_lsbs;

    assign iidx   = IADDR[ADDR_W+1:2];
    assign didx   = DADDR[ADDR_W+1:2];
    assign irange = (IADDR[31:ADDR_W+2] == '0);
    assign drange = (DADDR[31:ADDR_W+2] == '0);
    assign unused_addr_lsbs = ^{IADDR[1:0], DADDR[1:0]};

    // ------------------------------------------------------------------
    // Data-path control
    // ------------------------------------------------------------------
    logic req;
    logic rd_only;
    logic enter_ack;
    logic load_datai;
    logic wr_fire;
    logic mem_we;
    logic ierr;
    logic derr;

    assign req     = RD | WR;
    // RD together with WR is treated as a write; the read half is dropped.
    assign rd_only = RD & ~WR;

    always_comb begin
        enter_ack = 1'b0;
        case (state)
            S_IDLE:  enter_ack = req & ~HAS_WAIT;
            S_WAIT:  enter_ack = (cnt <= 4'd1);
            default: enter_ack = 1'b0;
        endcase
    end

    // DATAI is loaded on the edge that enters ACK so it is valid in ACK.
    assign load_datai = enter_ack & rd_only;

    // Write commits on the edge leaving ACK, using the live WR so a request
    // withdrawn during WAIT never reaches memory.
    assign wr_fire = (state == S_ACK) & WR;
    // RES gating keeps a reset arriving right at the commit edge from
    // letting an abandoned write through.
    assign mem_we  = wr_fire & drange & ~RES;

    assign ierr = ~irange;
    assign derr = (load_datai & ~drange) | (wr_fire & (~drange | RD));

    // HLT: high for the accepting IDLE cycle and every WAIT cycle.
    assign HLT = ((state == S_IDLE) & req) | (state == S_WAIT);

    assign dbg_state = state;

    // ------------------------------------------------------------------
    // Control and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
            DATAI <= 32'd0;
            IDATA <= NOP_WORD;
            ERR   <= 1'b0;
        end else begin
            // Instruction fetch runs every cycle regardless of the data FSM.
            // Nonblocking read of mem gives read-before-write on a same-edge
            // data write to the same word.
            IDATA <= irange ? mem[iidx] : NOP_WORD;

            if (ierr | derr) begin
                ERR <= 1'b1;
            end

            if (load_datai) begin
                DATAI <= drange ? mem[didx] : 32'd0;
            end

            case (state)
                S_IDLE: begin
                    if (req) begin
                        cnt   <= CNT_INIT;
                        state <= HAS_WAIT ? S_WAIT : S_ACK;
                    end
                end
                S_WAIT: begin
                    // The transaction always runs to ACK, even if the core
                    // drops its request meanwhile.
                    cnt <= (cnt == 4'd0) ? 4'd0 : cnt - 4'd1;
                    if (cnt <= 4'd1) begin
                        state <= S_ACK;
                    end
                end
                S_ACK: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Memory array write port (no reset: contents survive RES)
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (mem_we) begin
            for (int n = 0; n < 4; n++) begin
                if (BE[n]) begin
                    mem[didx][8*n +: 8] <= DATAO[8*n +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dark_mem_responder.sv
// ---------------------------------------------------------------------------
// Bench for dark_mem_responder. Two instances share one clock: dut 0 with
// WAIT_CYC=1 and dut 1 with WAIT_CYC=3. Bus signals are arrays indexed by
// instance so one set of driver tasks serves both.
// ---------------------------------------------------------------------------
module tb_dark_mem_responder;

  localparam logic [31:0] NOP = 32'h00000013;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        res   [2];
  logic [31:0] iaddr [2];
  logic [31:0] idata [2];
  logic [31:0] daddr [2];
  logic [31:0] datao [2];
  logic [31:0] datai [2];
  logic [3:0]  be    [2];
  logic        wr    [2];
  logic        rd    [2];
  logic        hlt   [2];
  logic        err   [2];
  logic [1:0]  dbg   [2];

  int wc [2] = '{1, 3};

  dark_mem_responder #(.ADDR_W(10), .WAIT_CYC(1), .NOP_WORD(NOP)) dut0 (
    .CLK(clk), .RES(res[0]), .IADDR(iaddr[0]), .IDATA(idata[0]),
    .DADDR(daddr[0]), .DATAO(datao[0]), .DATAI(datai[0]), .BE(be[0]),
    .WR(wr[0]), .RD(rd[0]), .HLT(hlt[0]), .ERR(err[0]), .dbg_state(dbg[0])
  );

  dark_mem_responder #(.ADDR_W(10), .WAIT_CYC(3), .NOP_WORD(NOP)) dut1 (
    .CLK(clk), .RES(res[1]), .IADDR(iaddr[1]), .IDATA(idata[1]),
    .DADDR(daddr[1]), .DATAO(datao[1]), .DATAI(datai[1]), .BE(be[1]),
    .WR(wr[1]), .RD(rd[1]), .HLT(hlt[1]), .ERR(err[1]), .dbg_state(dbg[1])
  );

  // ---------------- scoreboard / reference model ----------------
  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] model_mem   [2][1024];
  logic [31:0] model_datai [2];
  logic        model_err   [2];

  task automatic check(input string nm, input int k, input logic [31:0] act, input logic [31:0] expd);
    n_checks++;
    if (act !== expd) begin
      n_fail++;
      $display("FAIL %s (dut%0d): got %h expected %h", nm, k, act, expd);
    end
  endtask

  // Bus transaction as the specification describes it, in plain terms:
  // in-range means below 4 KiB, write merges enabled bytes, RD+WR is a write
  // plus an error, out-of-range reads return 0 and flag an error.
  function automatic void model_access(input int k, input logic r, input logic w,
                                       input logic [31:0] addr, input logic [31:0] d,
                                       input logic [3:0] b);
    logic [31:0] a;
    int          idx;
    bit          inr;
    a   = addr;
    inr = (a < 32'h0000_1000);
    idx = int'(a[11:2]);
    if (w) begin
      if (r) model_err[k] = 1'b1;
      if (!inr) model_err[k] = 1'b1;
      else begin
        for (int n = 0; n < 4; n++)
          if (b[n]) model_mem[k][idx][8*n +: 8] = d[8*n +: 8];
      end
    end else if (r) begin
      if (inr) model_datai[k] = model_mem[k][idx];
      else begin
        model_datai[k] = 32'd0;
        model_err[k]   = 1'b1;
      end
    end
  endfunction

  // ---------------- driver tasks ----------------
  // Entered just after a rising edge with the FSM idle. Counts HLT cycles,
  // captures DATAI in the ACK cycle, releases the request after the edge
  // that leaves ACK.
  task automatic access(input int k, input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] b,
                        output int nh, output logic [31:0] rdat);
    rd[k] = r; wr[k] = w; daddr[k] = a; datao[k] = d; be[k] = b;
    nh = 0;
    forever begin
      @(negedge clk);
      if (!hlt[k]) break;
      nh++;
      if (nh > 40) break;
      @(posedge clk);
    end
    rdat = datai[k];
    @(posedge clk);
    #1;
    rd[k] = 1'b0; wr[k] = 1'b0;
  endtask

  task automatic do_op(input int k, input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] b,
                       input logic chk, input logic [31:0] expd, input string nm);
    int          nh;
    logic [31:0] rdat;
    access(k, r, w, a, d, b, nh, rdat);
    check({nm, "_hlt_cycles"}, k, 32'(nh), 32'(wc[k]));
    if (chk) check({nm, "_datai"}, k, rdat, expd);
    model_access(k, r, w, a, d, b);
    check({nm, "_err"}, k, {31'd0, err[k]}, {31'd0, model_err[k]});
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic        chk;
    logic [31:0] expd;
  } vec_t;

  vec_t vecs [12];

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- main sequence ----------------
  initial begin
    int          n;
    int          idx;
    int          op;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp_i;
    logic [31:0] prev;

    vecs[0]  = '{1'b0, 1'b1, 32'h0000_0010, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0};
    vecs[1]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,        4'h0, 1'b1, 32'hDEADBEEF};
    vecs[2]  = '{1'b0, 1'b1, 32'h0000_0020, 32'h11223344, 4'hF, 1'b0, 32'h0};
    vecs[3]  = '{1'b0, 1'b1, 32'h0000_0020, 32'hAABBCCDD, 4'h5, 1'b0, 32'h0};
    vecs[4]  = '{1'b1, 1'b0, 32'h0000_0020, 32'h0,        4'h0, 1'b1, 32'h11BB33DD};
    vecs[5]  = '{1'b0, 1'b1, 32'h0000_0024, 32'h01020304, 4'hF, 1'b0, 32'h0};
    vecs[6]  = '{1'b0, 1'b1, 32'h0000_0024, 32'hFFFFFFFF, 4'h0, 1'b0, 32'h0};
    vecs[7]  = '{1'b1, 1'b0, 32'h0000_0024, 32'h0,        4'h0, 1'b1, 32'h01020304};
    vecs[8]  = '{1'b0, 1'b1, 32'h0000_0013, 32'h00000055, 4'h1, 1'b0, 32'h0};
    vecs[9]  = '{1'b1, 1'b0, 32'h0000_0011, 32'h0,        4'h0, 1'b1, 32'hDEADBE55};
    vecs[10] = '{1'b0, 1'b1, 32'h0000_0FFC, 32'h12345678, 4'hF, 1'b0, 32'h0};
    vecs[11] = '{1'b1, 1'b0, 32'h0000_0FFE, 32'h0,        4'h0, 1'b1, 32'h12345678};

    for (int k = 0; k < 2; k++) begin
      res[k] = 1'b1; iaddr[k] = 32'd0; daddr[k] = 32'd0; datao[k] = 32'd0;
      be[k] = 4'd0; wr[k] = 1'b0; rd[k] = 1'b0;
      model_datai[k] = 32'd0; model_err[k] = 1'b0;
    end

    // Reset values while RES is held high.
    #12;
    for (int k = 0; k < 2; k++) begin
      check("rst_hlt",   k, {31'd0, hlt[k]}, 32'd0);
      check("rst_datai", k, datai[k], 32'd0);
      check("rst_idata", k, idata[k], NOP);
      check("rst_err",   k, {31'd0, err[k]}, 32'd0);
      check("rst_state", k, {30'd0, dbg[k]}, 32'd0);
    end

    // Release; the first access starts right away, so its HLT count also
    // confirms acceptance on the first edge with RES low.
    @(posedge clk);
    #1;
    res[0] = 1'b0; res[1] = 1'b0;

    // Table-driven vectors on both wait settings.
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 12; i++)
        do_op(k, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].be,
              vecs[i].chk, vecs[i].expd, $sformatf("vec%0d", i));

    // Randomized traffic in a 32-word window against the model.
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 32; i++)
        do_op(k, 1'b0, 1'b1, 32'(i * 4), $urandom, 4'hF, 1'b0, 32'h0, "fill");
      for (int i = 0; i < 40; i++) begin
        idx      = $urandom_range(0, 31);
        iaddr[k] = 32'(idx * 4);
        exp_i    = model_mem[k][idx];
        idx      = $urandom_range(0, 31);
        a        = 32'(idx * 4 + $urandom_range(0, 3));
        op       = $urandom_range(0, 2);
        if (op == 0) begin
          d = $urandom;
          do_op(k, 1'b0, 1'b1, a, d, 4'($urandom_range(0, 15)), 1'b0, 32'h0, "rnd_wr");
        end else begin
          do_op(k, 1'b1, 1'b0, a, 32'h0, 4'h0, 1'b1, model_mem[k][idx], "rnd_rd");
        end
        check("rnd_idata", k, idata[k], exp_i);
      end
      iaddr[k] = 32'd0;
    end

    // Request withdrawn during WAIT: FSM completes, write suppressed.
    do_op(1, 1'b0, 1'b1, 32'h50, 32'h00000077, 4'hF, 1'b0, 32'h0, "drop_pre");
    rd[1] = 1'b0; wr[1] = 1'b1; daddr[1] = 32'h50; datao[1] = 32'hFFFFFFFF; be[1] = 4'hF;
    @(posedge clk);
    #1;
    wr[1] = 1'b0;
    n = 0;
    while (hlt[1] && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drop_hlt_release", 1, {31'd0, hlt[1]}, 32'd0);
    @(posedge clk);
    #1;
    do_op(1, 1'b1, 1'b0, 32'h50, 32'h0, 4'h0, 1'b1, 32'h00000077, "drop_rd");

    // RD and WR together, with the instruction port on the same word.
    do_op(1, 1'b0, 1'b1, 32'h40, 32'h00000099, 4'hF, 1'b0, 32'h0, "rw_pre");
    iaddr[1] = 32'h40;
    prev     = model_datai[1];
    do_op(1, 1'b1, 1'b1, 32'h40, 32'h00000005, 4'hF, 1'b1, prev, "rw_both");
    check("rw_idata_old", 1, idata[1], 32'h00000099);
    @(posedge clk);
    #1;
    check("rw_idata_new", 1, idata[1], 32'h00000005);
    check("rw_datai_kept", 1, datai[1], prev);
    check("rw_err_sticky", 1, {31'd0, err[1]}, 32'd1);
    do_op(1, 1'b1, 1'b0, 32'h40, 32'h0, 4'h0, 1'b1, 32'h00000005, "rw_rd");

    // Reset in the second HLT cycle of a write.
    do_op(1, 1'b0, 1'b1, 32'h30, 32'hA5A5A5A5, 4'hF, 1'b0, 32'h0, "rstw_pre");
    rd[1] = 1'b0; wr[1] = 1'b1; daddr[1] = 32'h30; datao[1] = 32'h0; be[1] = 4'hF;
    @(posedge clk);
    #1;
    check("rstw_hlt_before", 1, {31'd0, hlt[1]}, 32'd1);
    res[1] = 1'b1;
    wr[1]  = 1'b0;
    #1;
    check("rstw_hlt",   1, {31'd0, hlt[1]}, 32'd0);
    check("rstw_idata", 1, idata[1], NOP);
    check("rstw_err",   1, {31'd0, err[1]}, 32'd0);
    check("rstw_datai", 1, datai[1], 32'd0);
    check("rstw_state", 1, {30'd0, dbg[1]}, 32'd0);
    model_err[1]   = 1'b0;
    model_datai[1] = 32'd0;
    @(posedge clk);
    #1;
    res[1]   = 1'b0;
    iaddr[1] = 32'h30;
    do_op(1, 1'b1, 1'b0, 32'h30, 32'h0, 4'h0, 1'b1, 32'hA5A5A5A5, "rstw_rd");
    check("rstw_idata_mem", 1, idata[1], 32'hA5A5A5A5);

    // Instruction fetch out of range.
    iaddr[1] = 32'h2000_0000;
    @(posedge clk);
    #1;
    check("ifetch_oor_idata", 1, idata[1], NOP);
    check("ifetch_oor_err",   1, {31'd0, err[1]}, 32'd1);
    model_err[1] = 1'b1;
    iaddr[1] = 32'd0;

    // Data access out of range (aliases word 0 if the decode were wrong).
    do_op(0, 1'b0, 1'b1, 32'h0, 32'h0BADC0DE, 4'hF, 1'b0, 32'h0, "oor_pre");
    do_op(0, 1'b1, 1'b0, 32'h0001_0000, 32'h0, 4'h0, 1'b1, 32'h0, "oor_rd");
    do_op(0, 1'b0, 1'b1, 32'h0001_0000, 32'hFFFFFFFF, 4'hF, 1'b0, 32'h0, "oor_wr");
    do_op(0, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h0BADC0DE, "oor_chk");
    check("oor_err_sticky", 0, {31'd0, err[0]}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dark_mem_responder.md
DARK_MEM_RESPONDER -- requirements
Module: dark_mem_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, word-address width (memory depth 2**ADDR_W 32-bit words).
REQ-002 SHALL have parameter WAIT_CYC, default 1, legal range 1..15, number of HLT cycles per data access.
REQ-003 SHALL have parameter NOP_WORD, default 32'h00000013, IDATA reset value.
REQ-004 CLK  input  1  single clock; all state updates on rising edge.
REQ-005 RES  input  1  reset, asynchronous, active-high.
REQ-006 IADDR  input  32  instruction fetch byte address from core.
REQ-007 IDATA  output  32  registered instruction word.
REQ-008 DADDR  input  32  data byte address from core.
REQ-009 DATAO  input  32  write data from core.
REQ-010 DATAI  output  32  registered read data to core.
REQ-011 BE  input  4  byte enables; BE[n] selects bits 8n+7:8n.
REQ-012 WR  input  1  data write request.
REQ-013 RD  input  1  data read request.
REQ-014 HLT  output  1  stall to core; core holds DADDR/DATAO/BE/WR/RD stable while HLT=1.
REQ-015 ERR  output  1  sticky error flag.

Function
REQ-016 Address decode SHALL use word index ADDR[ADDR_W+1:2]; access in-range only when ADDR[31:ADDR_W+2]==0; ADDR[1:0] ignored.
REQ-017 Instruction port SHALL load IDATA <= mem[IADDR index] every cycle, independent of HLT and data FSM; out-of-range IADDR loads NOP_WORD and sets ERR.
REQ-018 Data FSM SHALL have states IDLE, WAIT, ACK; 4-bit down-counter CNT.
REQ-019 IDLE: request = RD|WR; on request, CNT <= WAIT_CYC-1, next state WAIT if WAIT_CYC>1, else ACK; no request stays IDLE.
REQ-020 WAIT: CNT decrements each cycle; when CNT==1 (or 0) next state ACK.
REQ-021 ACK: next state IDLE unconditionally; a request present in the following IDLE cycle starts a new transaction.
REQ-022 HLT SHALL be combinational: 1 in IDLE when request, 1 in WAIT, 0 in ACK and in IDLE without request; HLT high exactly WAIT_CYC cycles per access.
REQ-023 Read: DATAI SHALL be loaded with mem[DADDR index] on the edge entering ACK; DATAI holds value until next read load; out-of-range read loads 0 and sets ERR.
REQ-024 Write: on the edge leaving ACK, byte lanes with BE[n]=1 SHALL be written from DATAO; BE=0 writes nothing; out-of-range write ignored, sets ERR.
REQ-025 RD and WR both high at request SHALL be treated as write only; DATAI unchanged; ERR set.
REQ-026 Same-edge instruction read and data write to same word SHALL return old data on IDATA (read-before-write).
REQ-027 ERR SHALL set on any error condition above and stay 1 until RES.
REQ-028 Request dropped by core before ACK (RD=WR=0 in WAIT) SHALL not abort: FSM completes to ACK/IDLE, write with current (zero) WR suppressed.

Reset
REQ-029 While RES=1: state IDLE, CNT=0, HLT=0 (no request) , DATAI=0, IDATA=NOP_WORD, ERR=0.
REQ-030 RES asserted mid-transaction SHALL abandon it: pending write not performed, memory contents unchanged by reset.
REQ-031 First request after RES release SHALL be accepted on the first clock edge with RES=0.

Verification
REQ-032 WAIT_CYC=1: WR=1, DADDR=0x10, DATAO=0xDEADBEEF, BE=4'hF -> HLT=1 one cycle, ACK next cycle, then RD of 0x10 returns DATAI=0xDEADBEEF after 1 HLT cycle.
REQ-033 WAIT_CYC=3: RD at 0x10 -> HLT high 3 consecutive cycles, 0 in ACK cycle, DATAI valid in ACK cycle.
REQ-034 Byte lanes: word 0x20 = 0x11223344, write BE=4'b0101 DATAO=0xAABBCCDD -> read returns 0x11BB33DD.
REQ-035 Out-of-range: RD at DADDR=0x0001_0000 (ADDR_W=10) -> DATAI=0, ERR=1 and stays 1; write there leaves memory unchanged.
REQ-036 Reset mid-write: WR at 0x30 with WAIT_CYC=3, RES pulsed in 2nd HLT cycle -> HLT=0, IDATA=0x00000013, word 0x30 retains prior value.
REQ-037 RD&WR simultaneous at 0x40, DATAO=0x5 -> word 0x40 = 0x5, DATAI unchanged, ERR=1; same-edge IADDR=0x40 yields old word on IDATA.
